// File: rtl/orf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : orf_pkg
// Purpose : Shared constants for the operand register file: FunSel operation
//           codes, read-port select encodings and the default data width.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package orf_pkg;

  localparam int ORF_WIDTH = 16;

  // Operation applied to every enabled register at the clock edge
  localparam logic [2:0] ORF_DEC    = 3'b000;
  localparam logic [2:0] ORF_INC    = 3'b001;
  localparam logic [2:0] ORF_LOAD   = 3'b010;
  localparam logic [2:0] ORF_CLR    = 3'b011;
  localparam logic [2:0] ORF_LOADL0 = 3'b100;
  localparam logic [2:0] ORF_WRL    = 3'b101;
  localparam logic [2:0] ORF_WRH    = 3'b110;
  localparam logic [2:0] ORF_SEXT   = 3'b111;

  // Read-port select encodings: general registers first, then scratch
  localparam logic [2:0] SEL_R1 = 3'b000;
  localparam logic [2:0] SEL_R2 = 3'b001;
  localparam logic [2:0] SEL_R3 = 3'b010;
  localparam logic [2:0] SEL_R4 = 3'b011;
  localparam logic [2:0] SEL_S1 = 3'b100;
  localparam logic [2:0] SEL_S2 = 3'b101;
  localparam logic [2:0] SEL_S3 = 3'b110;
  localparam logic [2:0] SEL_S4 = 3'b111;

endpackage : orf_pkg
`default_nettype wire

// File: rtl/operand_register.sv
`default_nettype none
// ============================================================================
// Module  : operand_register
// Purpose : One WIDTH-bit register function unit: decrement, increment,
//           load, clear, low-byte load, byte-lane writes and sign-extend.
// Ports   : Clock  - rising-edge clock
//           Reset  - synchronous active-high clear
//           E      - enable; when low the register holds
//           FunSel - operation code (orf_pkg ORF_*)
//           I      - write data
//           Q      - register contents
// Rev     : 1.0  initial release
// ============================================================================
module operand_register
  import orf_pkg::*;
#(
  parameter int WIDTH = ORF_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = Q;
    case (FunSel)
      ORF_DEC:    q_next = Q - ONE;   // wraps naturally modulo 2^WIDTH
      ORF_INC:    q_next = Q + ONE;
      ORF_LOAD:   q_next = I;
      ORF_CLR:    q_next = '0;
      ORF_LOADL0: begin
        q_next      = '0;
        q_next[7:0] = I[7:0];
      end
      ORF_WRL:    q_next[7:0]  = I[7:0];
      // High lane is always sourced from the low byte of I
      ORF_WRH:    q_next[15:8] = I[7:0];
      ORF_SEXT:   q_next = {{(WIDTH-8){I[7]}}, I[7:0]};
      default:    q_next = Q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= '0;
    end else if (E) begin
      Q <= q_next;
    end
  end

endmodule : operand_register
`default_nettype wire

// File: rtl/operand_register_file.sv
`default_nettype none
// ============================================================================
// Module  : operand_register_file
// Purpose : Eight-entry operand store (R1-R4 general, S1-S4 scratch) with a
//           shared write port and two combinational read ports feeding the
//           ALU A and B inputs.
// Ports   : Clock   - rising-edge clock
//           Reset   - synchronous active-high, clears all registers
//           I       - write data
//           RegSel  - general register enables, MSB = R1 ... LSB = R4
//           ScrSel  - scratch register enables, MSB = S1 ... LSB = S4
//           FunSel  - operation applied to every enabled register
//           OutASel - read port A select (R1-R4, then S1-S4)
//           OutBSel - read port B select, same encoding
//           OutA    - selected register value for ALU A
//           OutB    - selected register value for ALU B
// Rev     : 1.0  initial release
// ============================================================================
module operand_register_file
  import orf_pkg::*;
#(
  parameter int WIDTH = ORF_WIDTH,
  parameter int NREG  = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [WIDTH-1:0]            I,
  input  logic [NREG-1:0]             RegSel,
  input  logic [NREG-1:0]             ScrSel,
  input  logic [2:0]                  FunSel,
  input  logic [$clog2(2*NREG)-1:0]   OutASel,
  input  logic [$clog2(2*NREG)-1:0]   OutBSel,
  output logic [WIDTH-1:0]            OutA,
  output logic [WIDTH-1:0]            OutB
);

  // Entries 0..NREG-1 are R1..R4, entries NREG..2*NREG-1 are S1..S4,
  // matching the read-select encoding directly.
  logic [WIDTH-1:0] regs [2*NREG];

  genvar k;
  generate
    for (k = 0; k < NREG; k++) begin : g_gen
      // Enable vectors are MSB-first: bit NREG-1 drives R1
      operand_register #(.WIDTH(WIDTH)) u_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (RegSel[NREG-1-k]),
        .FunSel (FunSel),
        .I      (I),
        .Q      (regs[k])
      );
    end : g_gen

    for (k = 0; k < NREG; k++) begin : g_scr
      operand_register #(.WIDTH(WIDTH)) u_reg (
        .Clock  (Clock),
        .Reset  (Reset),
        .E      (ScrSel[NREG-1-k]),
        .FunSel (FunSel),
        .I      (I),
        .Q      (regs[NREG+k])
      );
    end : g_scr
  endgenerate

  // Read ports come from register state only, so no path exists from I
  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule : operand_register_file
`default_nettype wire
